// File: rtl/i2c_tx_fetch_block.sv
// i2c_tx_fetch_block
// Read-side consumer of the I2C transmit FIFO. Pops bytes from the FIFO read
// port into a 2-entry buffer and presents them as a valid/ready byte stream
// to the transmit shift logic.
//
// Optional feature macro: I2C_TX_FETCH_COUNT_EN
//   defined   : programmable transfer length, tx_last_o marking, done_o pulse,
//               DRAIN state once every byte has been fetched.
//   undefined : free-running fetch; length_i ignored, tx_last_o/done_o tied
//               low, only abort_i returns the block to IDLE.

module i2c_tx_fetch_block #(
  parameter int data_size  = 8,
  parameter int count_size = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [count_size-1:0] length_i,
  input  logic                  abort_i,
  input  logic [data_size-1:0]  fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_read_inc_o,
  output logic [data_size-1:0]  tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  tx_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  underrun_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Two-entry output buffer with separate read/write pointers and occupancy.
  logic [data_size-1:0] buf_q [2];
  logic [data_size-1:0] buf_d [2];
  logic                 rdPtr_q, rdPtr_d;
  logic                 wrPtr_q, wrPtr_d;
  logic [1:0]           occ_q, occ_d;

  logic pop;
  logic handshake;
  logic fetchOpen;
  logic sendOwed;
  logic lastOwed;
  logic startAccept;

`ifdef I2C_TX_FETCH_COUNT_EN
  logic [count_size-1:0] fetchCnt_q, fetchCnt_d;
  logic [count_size-1:0] sendCnt_q, sendCnt_d;
  logic                  done_q, done_d;

  assign fetchOpen = (fetchCnt_q != '0);
  assign sendOwed  = (sendCnt_q != '0);
  assign lastOwed  = (sendCnt_q == count_size'(1));
`else
  logic unusedLength;

  assign unusedLength = ^length_i;
  assign fetchOpen    = 1'b1;
  assign sendOwed     = 1'b1;
  assign lastOwed     = 1'b0;
`endif

  // A start is only honoured from IDLE and loses to a simultaneous abort.
  assign startAccept = (state_q == IDLE) && start_i && !abort_i;

  // Pop whenever fetching, room in the buffer, FIFO has data and bytes are still owed;
  // an abort or a reset cycle never pops so nothing is pulled out of the FIFO and then lost.
  assign pop = (state_q == FETCH) && !fifo_empty_i && (occ_q != 2'd2) &&
               fetchOpen && !abort_i && reset_n_i;

  // A byte leaves the buffer when the consumer accepts the head entry.
  assign handshake = tx_valid_o && tx_ready_i;

  // State register.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: abort wins from any state, otherwise walk IDLE -> FETCH (-> DRAIN).
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
`ifdef I2C_TX_FETCH_COUNT_EN
          if (start_i && (length_i != '0)) begin
            state_d = FETCH;
          end
`else
          if (start_i) begin
            state_d = FETCH;
          end
`endif
        end
        FETCH: begin
`ifdef I2C_TX_FETCH_COUNT_EN
          if (pop && (fetchCnt_q == count_size'(1))) begin
            state_d = DRAIN;
          end
`else
          state_d = FETCH;
`endif
        end
        DRAIN: begin
`ifdef I2C_TX_FETCH_COUNT_EN
          if (handshake && (sendCnt_q == count_size'(1))) begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: everything is derived from registered state plus the FIFO empty flag.
  always_comb begin
    busy_o          = (state_q != IDLE);
    tx_valid_o      = (occ_q != 2'd0);
    tx_data_o       = tx_valid_o ? buf_q[rdPtr_q] : '0;
    fifo_read_inc_o = pop;
    tx_last_o       = tx_valid_o && lastOwed;
    underrun_o      = busy_o && sendOwed && !tx_valid_o && fifo_empty_i;
`ifdef I2C_TX_FETCH_COUNT_EN
    done_o          = done_q;
`else
    done_o          = 1'b0;
`endif
  end

  // Buffer next state: abort flushes, otherwise push on pop and retire on handshake.
  always_comb begin
    buf_d   = buf_q;
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    occ_d   = occ_q;
    if (abort_i) begin
      rdPtr_d = 1'b0;
      wrPtr_d = 1'b0;
      occ_d   = 2'd0;
    end else begin
      if (pop) begin
        buf_d[wrPtr_q] = fifo_data_i;
        wrPtr_d        = !wrPtr_q;
      end
      if (handshake) begin
        rdPtr_d = !rdPtr_q;
      end
      case ({pop, handshake})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Buffer registers; cleared by reset so tx_data_o starts at zero.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rdPtr_q  <= 1'b0;
      wrPtr_q  <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      buf_q    <= buf_d;
      rdPtr_q  <= rdPtr_d;
      wrPtr_q  <= wrPtr_d;
      occ_q    <= occ_d;
    end
  end

`ifdef I2C_TX_FETCH_COUNT_EN
  // Transfer counters: loaded on an accepted start, stepped by pops and handshakes.
  always_comb begin
    fetchCnt_d = fetchCnt_q;
    sendCnt_d  = sendCnt_q;
    if (abort_i) begin
      fetchCnt_d = '0;
      sendCnt_d  = '0;
    end else if (startAccept) begin
      fetchCnt_d = length_i;
      sendCnt_d  = length_i;
    end else begin
      if (pop) begin
        fetchCnt_d = fetchCnt_q - count_size'(1);
      end
      if (handshake && sendOwed) begin
        sendCnt_d = sendCnt_q - count_size'(1);
      end
    end
  end

  // Done pulse: a zero-length start, or the final handshake out of DRAIN.
  always_comb begin
    done_d = 1'b0;
    if (!abort_i) begin
      if (startAccept && (length_i == '0)) begin
        done_d = 1'b1;
      end else if ((state_q == DRAIN) && handshake && (sendCnt_q == count_size'(1))) begin
        done_d = 1'b1;
      end
    end
  end

  // Counter and done registers.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      fetchCnt_q <= '0;
      sendCnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      fetchCnt_q <= fetchCnt_d;
      sendCnt_q  <= sendCnt_d;
      done_q     <= done_d;
    end
  end
`else
  logic unusedStart;

  assign unusedStart = startAccept;
`endif

endmodule

// File: tb/tb_i2c_tx_fetch_block.sv
// tb_i2c_tx_fetch_block
// Directed bench for i2c_tx_fetch_block. A small array-based FIFO model feeds
// the read port; every comparison is an immediate assertion in checkOutput.
// Sections guarded by I2C_TX_FETCH_COUNT_EN follow the build of the design.

module tb_i2c_tx_fetch_block;

  logic       clock_i;
  logic       reset_n_i;
  logic       start_i;
  logic [7:0] length_i;
  logic       abort_i;
  logic [7:0] fifo_data_i;
  logic       fifo_empty_i;
  logic       fifo_read_inc_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       tx_last_o;
  logic       busy_o;
  logic       done_o;
  logic       underrun_o;

  int total = 0;
  int bad   = 0;
  int popWhileEmpty = 0;

  // Upstream FIFO model: bench writes, DUT pops.
  logic [7:0] fifoMem [0:63];
  logic [6:0] fifoWr;
  logic [6:0] fifoRd = '0;

  assign fifo_empty_i = (fifoWr == fifoRd);
  assign fifo_data_i  = fifoMem[fifoRd[5:0]];

  i2c_tx_fetch_block #(
    .data_size  (8),
    .count_size (8)
  ) dut (
    .clock_i         (clock_i),
    .reset_n_i       (reset_n_i),
    .start_i         (start_i),
    .length_i        (length_i),
    .abort_i         (abort_i),
    .fifo_data_i     (fifo_data_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_read_inc_o (fifo_read_inc_o),
    .tx_data_o       (tx_data_o),
    .tx_valid_o      (tx_valid_o),
    .tx_ready_i      (tx_ready_i),
    .tx_last_o       (tx_last_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .underrun_o      (underrun_o)
  );

  // Clock: rising edges at 5, 15, 25 ...
  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  // FIFO read side; also records any pop requested while the FIFO is empty.
  always @(posedge clock_i) begin
    if (fifo_read_inc_o === 1'b1) begin
      if (fifo_empty_i) begin
        popWhileEmpty <= popWhileEmpty + 1;
      end else begin
        fifoRd <= fifoRd + 7'd1;
      end
    end
  end

  task automatic pushByte(input logic [7:0] b);
    fifoMem[fifoWr[5:0]] = b;
    fifoWr = fifoWr + 7'd1;
  endtask

  // Drive one cycle's inputs just after the falling edge, then let them settle.
  task automatic applyStimulus(input logic s, input logic [7:0] len, input logic ab, input logic rdy);
    @(negedge clock_i);
    start_i    = s;
    length_i   = len;
    abort_i    = ab;
    tx_ready_i = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},     busy_o,          0);
    checkOutput({tag, "_valid"},    tx_valid_o,      0);
    checkOutput({tag, "_data"},     tx_data_o,       0);
    checkOutput({tag, "_readInc"},  fifo_read_inc_o, 0);
    checkOutput({tag, "_done"},     done_o,          0);
    checkOutput({tag, "_underrun"}, underrun_o,      0);
    checkOutput({tag, "_last"},     tx_last_o,       0);
  endtask

  initial begin
    int got;
    logic lastSeen;

    reset_n_i  = 1'b0;
    start_i    = 1'b0;
    length_i   = 8'd0;
    abort_i    = 1'b0;
    tx_ready_i = 1'b0;
    fifoWr     = '0;

    $display("[TB] reset");
    applyStimulus(0, 0, 0, 0);
    checkIdleOutputs("reset");
    reset_n_i = 1'b1;

`ifndef I2C_TX_FETCH_COUNT_EN
    $display("[TB] free-running fetch with backpressure");
    applyStimulus(0, 0, 0, 0);
    pushByte(8'hA1); pushByte(8'hB2); pushByte(8'hC3);
    #1;
    checkOutput("idleNoPop", fifo_read_inc_o, 0);
    applyStimulus(1, 8'd3, 0, 0);
    checkOutput("startCycleBusy", busy_o, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("n1Busy", busy_o, 1);
    checkOutput("n1ReadInc", fifo_read_inc_o, 1);
    checkOutput("n1Valid", tx_valid_o, 0);
    checkOutput("n1Underrun", underrun_o, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("n2Valid", tx_valid_o, 1);
    checkOutput("n2Data", tx_data_o, 8'hA1);
    checkOutput("n2ReadInc", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fullNoPop", fifo_read_inc_o, 0);
    checkOutput("holdData3", tx_data_o, 8'hA1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("holdData4", tx_data_o, 8'hA1);
    checkOutput("holdLast", tx_last_o, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("releaseData", tx_data_o, 8'hA1);
    checkOutput("releaseReadInc", fifo_read_inc_o, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("secondData", tx_data_o, 8'hB2);
    checkOutput("secondReadInc", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("thirdData", tx_data_o, 8'hC3);
    checkOutput("emptyNoPop", fifo_read_inc_o, 0);
    checkOutput("thirdUnderrun", underrun_o, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("drainedValid", tx_valid_o, 0);
    checkOutput("drainedBusy", busy_o, 1);
    checkOutput("drainedUnderrun", underrun_o, 1);
    checkOutput("drainedDone", done_o, 0);

    $display("[TB] 10-byte stream");
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) pushByte(8'h10 + 8'(i));
    #1;
    got = 0;
    lastSeen = 1'b0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      if (c > 0) applyStimulus(0, 0, 0, 1);
      if (tx_last_o !== 1'b0) lastSeen = 1'b1;
      if (tx_valid_o === 1'b1) begin
        checkOutput("streamData", tx_data_o, 32'h10 + got);
        got++;
      end
    end
    checkOutput("streamCount", got, 10);
    checkOutput("streamLast", lastSeen, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("streamBusy", busy_o, 1);
    checkOutput("streamUnderrun", underrun_o, 1);
    checkOutput("streamDone", done_o, 0);

    $display("[TB] abort");
    applyStimulus(0, 0, 0, 0);
    pushByte(8'h55); pushByte(8'h66); pushByte(8'h77);
    #1;
    checkOutput("abPop1", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("abData1", tx_data_o, 8'h55);
    applyStimulus(0, 0, 0, 1);
    checkOutput("abFullNoPop", fifo_read_inc_o, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("abData2", tx_data_o, 8'h66);
    checkOutput("abortNoPop", fifo_read_inc_o, 0);
    applyStimulus(0, 0, 0, 0);
    checkIdleOutputs("afterAbort");
    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("abortBeatsStart", busy_o, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("restartBusy", busy_o, 1);
    checkOutput("restartPop", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("flushedData", tx_data_o, 8'h77);
    checkOutput("flushedValid", tx_valid_o, 1);

    $display("[TB] reset mid-transfer");
    applyStimulus(0, 0, 0, 0);
    pushByte(8'h88); pushByte(8'h99);
    #1;
    checkOutput("rsPop", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rsFull", fifo_read_inc_o, 0);
    reset_n_i = 1'b0;
    #1;
    checkOutput("resetNoPop", fifo_read_inc_o, 0);
    applyStimulus(0, 0, 0, 0);
    reset_n_i = 1'b1;
    #1;
    checkIdleOutputs("midReset");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("postResetBusy", busy_o, 1);
    checkOutput("postResetPop", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("postResetData", tx_data_o, 8'h99);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("finalIdle", busy_o, 0);
`else
    $display("[TB] length 3, ready high");
    applyStimulus(0, 0, 0, 1);
    pushByte(8'hA1); pushByte(8'hB2); pushByte(8'hC3);
    #1;
    applyStimulus(1, 8'd3, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("l3n1Busy", busy_o, 1);
    checkOutput("l3n1Pop", fifo_read_inc_o, 1);
    checkOutput("l3n1Valid", tx_valid_o, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("l3n2Data", tx_data_o, 8'hA1);
    checkOutput("l3n2Last", tx_last_o, 0);
    checkOutput("l3n2Pop", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("l3n3Data", tx_data_o, 8'hB2);
    checkOutput("l3n3Last", tx_last_o, 0);
    checkOutput("l3n3Pop", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("l3n4Data", tx_data_o, 8'hC3);
    checkOutput("l3n4Last", tx_last_o, 1);
    checkOutput("l3n4Pop", fifo_read_inc_o, 0);
    checkOutput("l3n4Done", done_o, 0);
    applyStimulus(1, 8'd3, 0, 0);
    pushByte(8'hA1); pushByte(8'hB2); pushByte(8'hC3);
    #1;
    checkOutput("l3n5Done", done_o, 1);
    checkOutput("l3n5Busy", busy_o, 0);
    checkOutput("l3n5Valid", tx_valid_o, 0);

    $display("[TB] backpressure, start in done cycle");
    applyStimulus(0, 0, 0, 0);
    checkOutput("bpDonePulse", done_o, 0);
    checkOutput("bpBusy", busy_o, 1);
    checkOutput("bpPop1", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("bpData", tx_data_o, 8'hA1);
    checkOutput("bpPop2", fifo_read_inc_o, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("bpHoldPop", fifo_read_inc_o, 0);
      checkOutput("bpHoldData", tx_data_o, 8'hA1);
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("bpRelData", tx_data_o, 8'hA1);
    checkOutput("bpRelPop", fifo_read_inc_o, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bpB2", tx_data_o, 8'hB2);
    checkOutput("bpB2Last", tx_last_o, 0);
    checkOutput("bpPop3", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bpC3", tx_data_o, 8'hC3);
    checkOutput("bpC3Last", tx_last_o, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("bpDone", done_o, 1);

    $display("[TB] underrun");
    applyStimulus(0, 0, 0, 1);
    pushByte(8'h11);
    #1;
    checkOutput("urDoneOff", done_o, 0);
    applyStimulus(1, 8'd4, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("urPop", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("urData11", tx_data_o, 8'h11);
    checkOutput("urNoUnder", underrun_o, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("urUnderrun", underrun_o, 1);
    checkOutput("urBusy", busy_o, 1);
    applyStimulus(0, 0, 0, 1);
    pushByte(8'h22); pushByte(8'h33); pushByte(8'h44);
    #1;
    checkOutput("urRefillPop", fifo_read_inc_o, 1);
    checkOutput("urCleared", underrun_o, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("urData22", tx_data_o, 8'h22);
    applyStimulus(0, 0, 0, 1);
    checkOutput("urData33", tx_data_o, 8'h33);
    checkOutput("urLast33", tx_last_o, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("urData44", tx_data_o, 8'h44);
    checkOutput("urLast44", tx_last_o, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("urDone", done_o, 1);
    checkOutput("urIdle", busy_o, 0);

    $display("[TB] zero length");
    applyStimulus(0, 0, 0, 0);
    pushByte(8'h5A);
    #1;
    applyStimulus(1, 8'd0, 0, 0);
    checkOutput("z0Pop", fifo_read_inc_o, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("z0Done", done_o, 1);
    checkOutput("z0Busy", busy_o, 0);
    checkOutput("z0Pop1", fifo_read_inc_o, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("z0DoneOff", done_o, 0);

    $display("[TB] abort after two handshakes");
    applyStimulus(0, 0, 0, 1);
    pushByte(8'h61); pushByte(8'h62); pushByte(8'h63); pushByte(8'h64);
    #1;
    applyStimulus(1, 8'd5, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("abPop", fifo_read_inc_o, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("ab5A", tx_data_o, 8'h5A);
    applyStimulus(0, 0, 0, 1);
    checkOutput("ab61", tx_data_o, 8'h61);
    applyStimulus(0, 0, 1, 1);
    checkOutput("abortNoPop", fifo_read_inc_o, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("abValid", tx_valid_o, 0);
    checkOutput("abBusy", busy_o, 0);
    checkOutput("abDone", done_o, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("abDoneLater", done_o, 0);
`endif

    applyStimulus(0, 0, 0, 0);
    checkOutput("popWhileEmpty", popWhileEmpty, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_tx_fetch_block.md
# i2c_tx_fetch_block

Read-side consumer of the I2C transmit FIFO. Pops bytes from the FIFO's read port, holds them in a 2-entry output buffer and presents them as a valid/ready byte stream to the I2C transmit shift logic, with a programmable transfer length, last-byte marking and a done pulse. Sits entirely in the FIFO read clock domain, directly downstream of the FIFO top block.

## Interface
- data_size, 8, byte width; must match the FIFO's data_size
- count_size, 8, width of the transfer-length counter
- clock_i  in  1  block clock; same clock as the FIFO read domain
- reset_n_i  in  1  reset, synchronous, active-low
- start_i  in  1  one-cycle pulse; begins a transfer; ignored while busy_o=1
- length_i  in  count_size  byte count, sampled on start_i
- abort_i  in  1  one-cycle pulse; ends the transfer immediately
- fifo_data_i  in  data_size  FIFO read data, combinational from the current read address
- fifo_empty_i  in  1  FIFO read-empty flag
- fifo_read_inc_o  out  1  FIFO read increment; one byte popped per high cycle
- tx_data_o  out  data_size  head-of-buffer byte
- tx_valid_o  out  1  tx_data_o is valid
- tx_ready_i  in  1  consumer accepts; a transfer occurs when tx_valid_o and tx_ready_i are both 1
- tx_last_o  out  1  tx_data_o is the final byte of the transfer
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse on normal completion
- underrun_o  out  1  consumer starved: busy, bytes still owed, buffer empty, FIFO empty

## Operation
- Reset (reset_n_i=0 at a clock edge): state IDLE, buffer cleared, counters 0. All outputs 0.
- States: IDLE, FETCH, DRAIN.
- IDLE: on start_i, load fetch_cnt=length_i and send_cnt=length_i.
  - If length_i≠0, go to FETCH.
  - If length_i=0, stay IDLE; done_o pulses next cycle; no pop.
- FETCH:
  - fifo_read_inc_o = !fifo_empty_i && occupancy<2 && fetch_cnt≠0. It is combinational from registered state and fifo_empty_i.
  - On a pop, fifo_data_i is written into the buffer at that edge and fetch_cnt decrements.
  - When fetch_cnt reaches 0, go to DRAIN.
- DRAIN: no pops. When send_cnt reaches 0, return to IDLE and pulse done_o for one cycle.
- Output handshake:
  - Each handshake decrements send_cnt and removes the head entry.
  - tx_last_o = tx_valid_o && send_cnt==1.
  - tx_data_o and tx_valid_o hold stable while tx_valid_o && !tx_ready_i.
- Buffer:
  - A simultaneous pop and handshake leaves occupancy unchanged.
  - Occupancy 1 with continuous tx_ready_i sustains one byte per cycle.
  - Buffer order is strictly FIFO.
- abort_i, any state:
  - fifo_read_inc_o=0 in the abort cycle.
  - Next cycle: IDLE, buffer flushed, counters 0, tx_valid_o=0, no done_o.
  - Bytes already popped are discarded.
  - abort_i has priority over start_i in the same cycle.
- underrun_o = busy_o && send_cnt≠0 && occupancy==0 && fifo_empty_i. It is informational only and has no effect on state.
- fifo_read_inc_o never asserts while fifo_empty_i=1, in IDLE, or in DRAIN.

## Timing
- start_i sampled at edge N: busy_o=1 from cycle N+1.
  - First possible fifo_read_inc_o is cycle N+1.
  - First tx_valid_o is cycle N+2, one cycle after the pop.
- Pop-to-valid latency: 1 cycle.
- Sustained throughput: 1 byte/cycle.
- Final handshake at edge M: busy_o=0 and done_o=1 in cycle M+1; done_o=0 in cycle M+2.
- start_i arriving in the done_o cycle is accepted.
- length_i=2^count_size−1 is the maximum; counters never wrap.

## Configuration
- Macro I2C_TX_FETCH_COUNT_EN.
- Defined: length counting, tx_last_o and done_o behave as above.
- Undefined:
  - length_i is ignored; start_i enters FETCH and pops whenever !fifo_empty_i && occupancy<2.
  - No DRAIN state; only abort_i returns the block to IDLE.
  - tx_last_o=0 and done_o=0 constant.
  - underrun_o = busy_o && occupancy==0 && fifo_empty_i.

## Test plan
- Reset mid-transfer, with reset_n_i=0 for 1 cycle during FETCH with 2 bytes buffered -> next cycle all outputs 0; no pop; a subsequent start works normally.
- FIFO holds 0xA1,0xB2,0xC3; start length=3; tx_ready_i=1 -> fifo_read_inc_o high cycles N+1..N+3; tx_data_o A1,B2,C3 on cycles N+2..N+4; tx_last_o only with C3; done_o at N+5.
- Same data, tx_ready_i=0 for 5 cycles -> exactly 2 pops then fifo_read_inc_o=0; tx_data_o=A1 held stable; releasing ready delivers B2, C3 in order.
- Start length=4 with only 1 byte in FIFO -> after that byte is accepted, underrun_o=1 and busy_o=1; writing 3 more bytes completes the transfer with done_o.
- Start length=0 -> done_o pulses next cycle; fifo_read_inc_o never asserts. Start length=5, abort after 2 handshakes -> next cycle tx_valid_o=0, busy_o=0, no done_o.
- Macro undefined: start, stream 10 bytes -> tx_last_o=0 throughout; busy_o stays 1 until abort_i.
